// File: rtl/shot_sequencer.sv
// Command-side sequencer for the web shooter: queues fire requests, holds trigger until
// the shooter answers, does a single refill-and-retry on refusal, and reports one status per command.
module shot_sequencer #(
  parameter int DEPTH        = 4,
  parameter int TRIG_TIMEOUT = 8,
  parameter int REFILL_HOLD  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_mode,
  input  logic [4:0] cmd_targets,
  output logic       trigger,
  output logic       refill,
  output logic [2:0] fire_mode,
  output logic [4:0] target_cnt,
  input  logic       shoot,
  input  logic       not_enough,
  output logic       done_valid,
  output logic [1:0] done_status,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TRIG_TIMEOUT + 1);
  localparam int HW = $clog2(REFILL_HOLD + 2);

  typedef enum logic [2:0] {IDLE, ARM, RELEASE, REFILL, GAP, REPORT} state_t;
  typedef enum logic [1:0] {OUT_FIRED, OUT_REFUSED, OUT_TIMEOUT} outcome_t;

  state_t         state;
  outcome_t       outcome;
  logic           retry;
  logic [TW-1:0]  tmo_cnt;
  logic [HW-1:0]  phase;

  logic [7:0]     mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           full, empty, push, pop;
  logic [7:0]     head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_mode, cmd_targets};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outcome     <= OUT_FIRED;
      retry       <= 1'b0;
      tmo_cnt     <= '0;
      phase       <= '0;
      trigger     <= 1'b0;
      refill      <= 1'b0;
      fire_mode   <= 3'b000;
      target_cnt  <= 5'd0;
      done_valid  <= 1'b0;
      done_status <= 2'b00;
      busy        <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            fire_mode  <= head[7:5];
            target_cnt <= head[4:0];
            retry      <= 1'b0;
            tmo_cnt    <= '0;
            trigger    <= 1'b1;
            busy       <= 1'b1;
            state      <= ARM;
          end
        end
        ARM: begin
          // shoot has priority over a simultaneous not_enough and over the timeout
          if (shoot || not_enough || (tmo_cnt == TW'(TRIG_TIMEOUT - 1))) begin
            outcome <= shoot ? OUT_FIRED : (not_enough ? OUT_REFUSED : OUT_TIMEOUT);
            trigger <= 1'b0;
            phase   <= '0;
            state   <= RELEASE;
          end else if (tmo_cnt != TW'(TRIG_TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RELEASE: begin
          if (phase == HW'(1)) begin
            phase <= '0;
            if (outcome == OUT_REFUSED && !retry) begin
              retry  <= 1'b1;
              refill <= 1'b1;
              state  <= REFILL;
            end else begin
              case (outcome)
                OUT_FIRED:   done_status <= retry ? 2'b01 : 2'b00;
                OUT_REFUSED: done_status <= 2'b10;
                default:     done_status <= 2'b11;
              endcase
              done_valid <= 1'b1;
              state      <= REPORT;
            end
          end else begin
            phase <= phase + HW'(1);
          end
        end
        REFILL: begin
          if (phase == HW'(REFILL_HOLD - 1)) begin
            phase  <= '0;
            refill <= 1'b0;
            state  <= GAP;
          end else begin
            phase <= phase + HW'(1);
          end
        end
        GAP: begin
          if (phase == HW'(1)) begin
            phase   <= '0;
            tmo_cnt <= '0;
            trigger <= 1'b1;
            state   <= ARM;
          end else begin
            phase <= phase + HW'(1);
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: a scripted shooter model answers each ARM, a monitor scores
// every completion against an expected queue, and hand sequences cover FIFO-full and async reset.
module tb_shot_sequencer;

  localparam int DEPTH        = 4;
  localparam int TRIG_TIMEOUT = 8;
  localparam int REFILL_HOLD  = 3;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_mode;
  logic [4:0] cmd_targets;
  logic       trigger, refill;
  logic [2:0] fire_mode;
  logic [4:0] target_cnt;
  logic       shoot, not_enough;
  logic       done_valid;
  logic [1:0] done_status;
  logic       busy;

  shot_sequencer #(.DEPTH(DEPTH), .TRIG_TIMEOUT(TRIG_TIMEOUT), .REFILL_HOLD(REFILL_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_targets(cmd_targets),
    .trigger(trigger), .refill(refill),
    .fire_mode(fire_mode), .target_cnt(target_cnt),
    .shoot(shoot), .not_enough(not_enough),
    .done_valid(done_valid), .done_status(done_status),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected completion record: command, status, trigger pulses, first pulse length, refill cycles.
  typedef struct packed {
    logic [2:0] mode;
    logic [4:0] targets;
    logic [1:0] status;
    logic [1:0] pulses;
    logic [3:0] len1;
    logic [2:0] ref_cyc;
  } exp_t;
  exp_t exp_q[$];

  // Shooter answer for one ARM attempt: resp 0 none, 1 shoot, 2 not_enough, 3 both; dly = ARM cycle.
  typedef struct {
    logic [1:0] resp;
    int         dly;
  } resp_t;
  resp_t resp_q[$];

  typedef struct {
    logic [2:0] mode;
    logic [4:0] targets;
    logic [1:0] r1;
    int         d1;
    logic [1:0] r2;
    int         d2;
    logic [1:0] status;
  } vec_t;
  vec_t vecs[8];

  // ---------------- shooter model ----------------
  int arm_cyc = 0;
  initial begin
    shoot = 1'b0;
    not_enough = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !trigger) begin
        arm_cyc = 0;
        shoot = 1'b0;
        not_enough = 1'b0;
      end else begin
        arm_cyc++;
        if (resp_q.size() > 0 && arm_cyc == resp_q[0].dly) begin
          shoot      = resp_q[0].resp[0];
          not_enough = resp_q[0].resp[1];
          void'(resp_q.pop_front());
        end else begin
          shoot = 1'b0;
          not_enough = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   prev_trig = 0, cur_len = 0, pulses = 0, len1 = 0, ref_cyc = 0;
  int   overlap = 0, mode_bad = 0, rel_low = 0, done_cnt = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_trig = 0; cur_len = 0; pulses = 0; len1 = 0; ref_cyc = 0;
      overlap = 0; mode_bad = 0; rel_low = 0;
    end else begin
      if (trigger && refill) overlap++;
      if (refill) ref_cyc++;
      if (trigger) begin
        if (prev_trig == 0) begin
          if (pulses > 0) chk("retry_gap", rel_low, 4 + REFILL_HOLD);
          else            chk("cmd_gap_nonzero", (rel_low >= 1), 1);
        end
        rel_low = 0;
        cur_len++;
        if (exp_q.size() > 0 && {fire_mode, target_cnt} != {exp_q[0].mode, exp_q[0].targets})
          mode_bad++;
      end else if (prev_trig != 0) begin
        pulses++;
        if (pulses == 1) len1 = cur_len;
        cur_len = 0;
      end
      if (done_valid) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_status", done_status, e.status);
          chk("trigger_pulses", pulses, e.pulses);
          chk("first_pulse_len", len1, e.len1);
          chk("refill_cycles", ref_cyc, e.ref_cyc);
          chk("trig_refill_overlap", overlap, 0);
          chk("mode_targets_stable", mode_bad, 0);
          chk("release_low_cycles", rel_low, 2);
        end
        pulses = 0; len1 = 0; ref_cyc = 0; overlap = 0; mode_bad = 0; rel_low = 0;
      end else if (!trigger) begin
        rel_low++;
      end
      prev_trig = trigger ? 1 : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_budget", exp_q.size(), 0);
      exp_q.delete();
    end
    resp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    logic retry;
    int   lat;
    retry = (v.r1 == 2'd2);
    exp_q.push_back('{mode: v.mode, targets: v.targets, status: v.status,
                      pulses: retry ? 2'd2 : 2'd1, len1: v.d1[3:0],
                      ref_cyc: retry ? 3'(REFILL_HOLD) : 3'd0});
    resp_q.push_back('{resp: v.r1, dly: v.d1});
    if (retry) resp_q.push_back('{resp: v.r2, dly: v.d2});
    cmd_mode = v.mode;
    cmd_targets = v.targets;
    cmd_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      cmd_valid = 1'b0;
      lat++;
    end while (!trigger && lat < 20);
    chk("enq_to_trigger", lat, 2);
    wait_drain();
    tick();
    chk("busy_after_report", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  int base;
  int n;

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode = 3'b000;
    cmd_targets = 5'd0;

    //         mode    tgt     r1  d1 r2  d2 status
    vecs[0] = '{3'b000, 5'd1,  2'd1, 3, 2'd0, 0, 2'b00};  // SWING, fired on 3rd ARM cycle
    vecs[1] = '{3'b011, 5'd16, 2'd2, 1, 2'd1, 1, 2'b01};  // SPLITTER, refill then fired
    vecs[2] = '{3'b111, 5'd5,  2'd2, 2, 2'd2, 1, 2'b10};  // GRENADE, refused twice
    vecs[3] = '{3'b110, 5'd3,  2'd0, 8, 2'd0, 0, 2'b11};  // TASER, silent shooter
    vecs[4] = '{3'b100, 5'd31, 2'd3, 1, 2'd0, 0, 2'b00};  // RAPID, shoot+not_enough together
    vecs[5] = '{3'b101, 5'd7,  2'd1, 8, 2'd0, 0, 2'b00};  // TRACER, shoot on last allowed cycle
    vecs[6] = '{3'b001, 5'd2,  2'd2, 8, 2'd1, 8, 2'b01};  // RICOCHET, both answers on last cycle
    vecs[7] = '{3'b011, 5'd0,  2'd2, 1, 2'd0, 8, 2'b11};  // retry attempt times out

    repeat (2) tick();
    chk("rst_trigger", trigger, 0);
    chk("rst_refill", refill, 0);
    chk("rst_fire_mode", fire_mode, 0);
    chk("rst_target_cnt", target_cnt, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_status", done_status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // FIFO full: first command stalls to timeout while five more are offered.
    exp_q.push_back('{mode: 3'b100, targets: 5'd9, status: 2'b11, pulses: 2'd1,
                      len1: 4'(TRIG_TIMEOUT), ref_cyc: 3'd0});
    resp_q.push_back('{resp: 2'd0, dly: TRIG_TIMEOUT});
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back('{mode: 3'(k), targets: 5'(k + 10), status: 2'b00, pulses: 2'd1,
                        len1: 4'd1, ref_cyc: 3'd0});
      resp_q.push_back('{resp: 2'd1, dly: 1});
    end
    cmd_mode = 3'b100;
    cmd_targets = 5'd9;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!trigger && n < 20) begin
      tick();
      n++;
    end
    chk("fifo_first_armed", trigger, 1);
    for (int k = 1; k <= 5; k++) begin
      chk("fifo_cmd_ready", cmd_ready, (k <= 4) ? 1 : 0);
      cmd_mode = (k <= 4) ? 3'(k) : 3'b101;
      cmd_targets = (k <= 4) ? 5'(k + 10) : 5'd31;
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("fifo_ready_held_low", cmd_ready, 0);
    n = 0;
    while (exp_q.size() > 4 && n < 50) begin
      tick();
      n++;
    end
    chk("fifo_stalled_reported", exp_q.size(), 4);
    base = done_cnt;
    wait_drain();
    repeat (20) tick();
    chk("fifo_queued_done", done_cnt - base, 4);
    chk("fifo_ready_after", cmd_ready, 1);

    // Asynchronous reset in the middle of REFILL drops the command silently.
    resp_q.push_back('{resp: 2'd2, dly: 1});
    cmd_mode = 3'b111;
    cmd_targets = 5'd20;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!refill && n < 40) begin
      tick();
      n++;
    end
    chk("reset_reached_refill", refill, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_refill_low", refill, 0);
    chk("async_trigger_low", trigger, 0);
    chk("async_busy_low", busy, 0);
    chk("async_cmd_ready", cmd_ready, 1);
    chk("async_done_valid", done_valid, 0);
    base = done_cnt;
    resp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("no_done_after_reset", done_cnt - base, 0);
    chk("idle_after_reset", busy, 0);
    chk("no_trigger_after_reset", trigger, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
